ahb_data_memory: RTL and testbench

// - AHB-Lite subordinate data memory serving the rf_processor load/store path; sole subordinate on the bus.
// - Zero-wait-state word-organised SRAM model with byte/halfword/word writes and a two-cycle ERROR response.
// - Contents are preloaded by simulation $readmemh into array `mem` (one 32-bit word per entry, hex per line).

---
 rtl/ahb_data_memory.sv | 127 ++++++++++++
 tb/tb_ahb_data_memory.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_data_memory.sv
// AHB-Lite zero-wait-state data memory with byte/half/word writes and a two-cycle ERROR response.
// Contents of mem are preloaded from outside by the simulation environment and are never cleared by reset.
//
// state   | meaning
// ST_OKAY | idle or legal data phase, HREADYOUT=1 HRESP=0
// ST_ERR1 | first error cycle, HREADYOUT=0 HRESP=1, address phase ignored
// ST_ERR2 | second error cycle, HREADYOUT=1 HRESP=1, new address phase accepted
module ahb_data_memory #(
    parameter int unsigned MEM_DEPTH = 32768,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);
    localparam int unsigned MEM_WORDS = MEM_DEPTH / 4;
    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_OKAY = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } state_t;

    logic [31:0]      mem [MEM_WORDS];
    state_t           state;
    logic             dp_rd;
    logic             dp_wr;
    logic [IDX_W-1:0] dp_idx;
    logic [3:0]       dp_lanes;

    logic [31:0]      offset;
    logic             accept;
    logic             aligned;
    logic             in_range;
    logic             legal;
    logic [3:0]       lanes;
    logic             unused_htrans;

    assign unused_htrans = HTRANS[0];

    always_comb begin
        offset   = HADDR - BASE_ADDR;
        accept   = HREADY && HTRANS[1] && (state != ST_ERR1);
        aligned  = 1'b0;
        lanes    = 4'b0000;
        case (HSIZE)
            3'd0: begin
                aligned = 1'b1;
                lanes   = 4'b0001 << HADDR[1:0];
            end
            3'd1: begin
                aligned = !HADDR[0];
                lanes   = HADDR[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                aligned = (HADDR[1:0] == 2'b00);
                lanes   = 4'b1111;
            end
            default: begin
                aligned = 1'b0;
                lanes   = 4'b0000;
            end
        endcase
        in_range = (HADDR >= BASE_ADDR) && (offset < MEM_DEPTH);
        legal    = aligned && in_range;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state     <= ST_OKAY;
            dp_rd     <= 1'b0;
            dp_wr     <= 1'b0;
            dp_idx    <= '0;
            dp_lanes  <= 4'b0000;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
        end else begin
            dp_rd <= 1'b0;
            dp_wr <= 1'b0;
            case (state)
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    if (accept && !legal) begin
                        state     <= ST_ERR1;
                        HREADYOUT <= 1'b0;
                        HRESP     <= 1'b1;
                    end else begin
                        state     <= ST_OKAY;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                        if (accept) begin
                            dp_rd    <= !HWRITE;
                            dp_wr    <= HWRITE;
                            dp_idx   <= offset[IDX_W+1:2];
                            dp_lanes <= lanes;
                        end
                    end
                end
            endcase
        end
    end

    // Write lands at the edge closing the data phase, so a following read sees it.
    always_ff @(posedge HCLK) begin
        if (HRESETn && dp_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (dp_lanes[i]) mem[dp_idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HRDATA = dp_rd ? mem[dp_idx] : 32'h0000_0000;

endmodule

// File: tb/tb_ahb_data_memory.sv
// Randomised scoreboard bench for ahb_data_memory: a byte-level reference model predicts each
// data-phase response when a transfer is accepted; a negedge monitor pops and compares.
module tb_ahb_data_memory;
    localparam int unsigned MEM_DEPTH = 32768;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    ahb_data_memory #(.MEM_DEPTH(MEM_DEPTH), .BASE_ADDR(32'h0)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HSIZE(HSIZE), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP)
    );

    // Sole subordinate on the bus: bus ready is our own ready.
    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic        rdy;
        logic        resp;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  model_bytes [int unsigned];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    function automatic logic [31:0] model_word(input int unsigned idx);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = model_bytes[idx*4 + k];
        return w;
    endfunction

    always @(negedge HCLK) begin
        exp_t e;
        if (mon_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{rdy: 1'b1, resp: 1'b0, data: 32'h0};
            checks++;
            if (HREADYOUT !== e.rdy || HRESP !== e.resp || HRDATA !== e.data) begin
                errors++;
                $display("FAIL resp_cycle t=%0t got rdy=%b resp=%b rdata=%h expected rdy=%b resp=%b rdata=%h",
                         $time, HREADYOUT, HRESP, HRDATA, e.rdy, e.resp, e.data);
            end
        end
    end

    // One bus transfer; retried while the bus is stalled. abort=1 leaves the model untouched
    // because the caller resets the DUT during the data phase.
    task automatic issue(input logic [31:0] a, input logic [2:0] s, input bit w,
                         input logic [1:0] t, input logic [31:0] wd, input bit abort);
        bit rdy;
        int tries = 0;
        HADDR  = a;
        HSIZE  = s;
        HWRITE = w;
        HTRANS = t;
        forever begin
            @(negedge HCLK);
            rdy = HREADY;
            @(posedge HCLK);
            #1;
            HWDATA = $urandom;
            if (!t[1]) return;
            if (rdy) begin
                bit legal;
                int unsigned nbytes;
                nbytes = 1 << s;
                legal  = (s <= 3'd2) && ((a % nbytes) == 0) && (a < MEM_DEPTH);
                if (!legal) begin
                    exp_q.push_back('{rdy: 1'b0, resp: 1'b1, data: 32'h0});
                    exp_q.push_back('{rdy: 1'b1, resp: 1'b1, data: 32'h0});
                end else if (w) begin
                    HWDATA = wd;
                    if (!abort) begin
                        for (int unsigned b = a; b < a + nbytes; b++)
                            model_bytes[b] = wd[8*(b%4) +: 8];
                    end
                    exp_q.push_back('{rdy: 1'b1, resp: 1'b0, data: 32'h0});
                end else begin
                    exp_q.push_back('{rdy: 1'b1, resp: 1'b0, data: model_word(a / 4)});
                end
                return;
            end
            tries++;
            if (tries > 8) begin
                errors++;
                $display("FAIL accept_timeout addr=%h got no acceptance within 8 cycles, expected acceptance", a);
                return;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) issue(32'h0, 3'd2, 1'b0, 2'b00, 32'h0, 1'b0);
    endtask

    initial begin
        HRESETn = 1'b0;
        HADDR   = 32'h0;
        HSIZE   = 3'd2;
        HWRITE  = 1'b0;
        HTRANS  = 2'b00;
        HWDATA  = 32'h0;
        @(posedge HCLK);
        #1;
        mon_en = 1'b1;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Known contents for words 0..63; word 3 holds DEADBEEF.
        for (int i = 0; i < 64; i++)
            issue(i * 4, 3'd2, 1'b1, 2'b10, (i == 3) ? 32'hDEAD_BEEF : $urandom, 1'b0);
        idle_cycles(1);

        issue(32'h0C, 3'd2, 1'b0, 2'b10, 32'h0, 1'b0);
        issue(32'h0D, 3'd0, 1'b1, 2'b10, 32'h0000_A500, 1'b0);
        issue(32'h0C, 3'd2, 1'b0, 2'b11, 32'h0, 1'b0);
        issue(32'h0E, 3'd1, 1'b1, 2'b10, 32'h1234_0000, 1'b0);
        issue(32'h0C, 3'd2, 1'b0, 2'b11, 32'h0, 1'b0);
        issue(32'h20, 3'd2, 1'b1, 2'b10, 32'h1111_2222, 1'b0);
        issue(32'h20, 3'd2, 1'b0, 2'b11, 32'h0, 1'b0);

        issue(32'h02, 3'd2, 1'b0, 2'b10, 32'h0, 1'b0);
        issue(MEM_DEPTH, 3'd2, 1'b1, 2'b10, 32'hFFFF_FFFF, 1'b0);
        issue(32'h01, 3'd1, 1'b1, 2'b10, 32'hFFFF_FFFF, 1'b0);
        issue(32'h00, 3'd3, 1'b0, 2'b10, 32'h0, 1'b0);
        issue(32'h00, 3'd2, 1'b0, 2'b10, 32'h0, 1'b0);

        issue(32'h0C, 3'd2, 1'b1, 2'b00, 32'h0, 1'b0);
        issue(32'h0C, 3'd2, 1'b1, 2'b01, 32'h0, 1'b0);
        issue(32'h0C, 3'd2, 1'b0, 2'b10, 32'h0, 1'b0);

        // Reset lands during the write data phase: write must be dropped.
        issue(32'h0C, 3'd2, 1'b1, 2'b10, 32'h5555_AAAA, 1'b1);
        HRESETn = 1'b0;
        HTRANS  = 2'b00;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        idle_cycles(1);
        issue(32'h0C, 3'd2, 1'b0, 2'b10, 32'h0, 1'b0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            logic [2:0]  s;
            int unsigned sel;
            sel = $urandom_range(0, 19);
            if (sel == 0)      a = MEM_DEPTH + $urandom_range(0, 64);
            else if (sel == 1) a = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            else               a = $urandom_range(0, 255);
            s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            issue(a, s, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, 1'b0);
        end

        idle_cycles(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d pending responses, expected 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
